// File: rtl/adder_exhaustive_checker.sv
// On-chip exhaustive self-test for a WIDTH-bit adder with carry-in: sweeps every {cin, a, b}
// and checks the adder's {cout, sum}. Define STOP_ON_FAIL_EN to end the sweep on the first mismatch.
module adder_exhaustive_checker #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   output logic               cin,
   input  logic [WIDTH-1:0]   dut_sum,
   input  logic               dut_cout,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [2*WIDTH+1:0] err_count,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b,
   output logic               fail_cin
);

   localparam int VW = 2*WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [VW-1:0]      r_vec;
   logic               r_error;
   logic [2*WIDTH+1:0] r_err_count;
   logic [WIDTH-1:0]   r_fail_a;
   logic [WIDTH-1:0]   r_fail_b;
   logic               r_fail_cin;

   logic [WIDTH:0]     w_golden;
   logic               w_mismatch;
   logic               w_last;
   logic               w_launch;
   logic               w_stop;

   // Vector layout {cin, a, b}: a plain increment gives b fastest, then a, then cin.
   assign b   = r_vec[WIDTH-1:0];
   assign a   = r_vec[2*WIDTH-1:WIDTH];
   assign cin = r_vec[2*WIDTH];

   assign w_golden   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign w_mismatch = ({dut_cout, dut_sum} != w_golden);
   assign w_last     = &r_vec;
   assign w_launch   = start & ~abort & (r_state != S_RUN);

`ifdef STOP_ON_FAIL_EN
   assign w_stop = w_last | w_mismatch;
`else
   assign w_stop = w_last;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if (w_stop) w_state_next = S_DONE;
         S_DONE:  if (start) w_state_next = S_RUN;
         default: w_state_next = S_IDLE;
      endcase
      if (abort) w_state_next = S_IDLE;
   end

   always_comb begin
      busy = (r_state == S_RUN);
      done = (r_state == S_DONE);
   end

   // Abort freezes the datapath: the vector on the bus at the abort edge is not scored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec       <= '0;
         r_error     <= 1'b0;
         r_err_count <= '0;
         r_fail_a    <= '0;
         r_fail_b    <= '0;
         r_fail_cin  <= 1'b0;
      end else if (w_launch) begin
         r_vec       <= '0;
         r_error     <= 1'b0;
         r_err_count <= '0;
         r_fail_a    <= '0;
         r_fail_b    <= '0;
         r_fail_cin  <= 1'b0;
      end else if ((r_state == S_RUN) && !abort) begin
         if (w_mismatch) begin
            r_error <= 1'b1;
            if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
            if (!r_error) begin
               r_fail_a   <= a;
               r_fail_b   <= b;
               r_fail_cin <= cin;
            end
         end
         if (!w_stop) r_vec <= r_vec + 1'b1;
      end
   end

   assign error     = r_error;
   assign err_count = r_err_count;
   assign fail_a    = r_fail_a;
   assign fail_b    = r_fail_b;
   assign fail_cin  = r_fail_cin;

endmodule

// File: tb/tb_adder_exhaustive_checker.sv
// Bench for adder_exhaustive_checker: faulty adders modelled in the bench, expectations from an
// independent sweep model (honours STOP_ON_FAIL_EN).
module tb_adder_exhaustive_checker;

`ifdef STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // WIDTH=4 instance
   logic       start4 = 1'b0, abort4 = 1'b0;
   logic [3:0] a4, b4, sum4, fa4, fb4;
   logic       cin4, cout4, busy4, done4, err4, fcin4;
   logic [9:0] cnt4;
   int         mode4 = 0, target4 = 0, out4;

   // WIDTH=1 instance
   logic       start1 = 1'b0, abort1 = 1'b0;
   logic [0:0] a1, b1, sum1, fa1, fb1;
   logic       cin1, cout1, busy1, done1, err1, fcin1;
   logic [3:0] cnt1;
   int         mode1 = 0, target1 = 0, out1;

   // Adder under test: 0 good, 1 sum[0] stuck 0, 2 cout stuck 0, 3 cout inverted, 4 one bad vector
   function automatic int adder_out(int w, int mode, int target, int av, int bv, int cv);
      int g;
      int idx;
      g   = av + bv + cv;
      idx = (cv << (2*w)) | (av << w) | bv;
      case (mode)
         1:       return g & ~1;
         2:       return g & ((1 << w) - 1);
         3:       return g ^ (1 << w);
         4:       return (idx == target) ? (g ^ 1) : g;
         default: return g;
      endcase
   endfunction

   always_comb out4 = adder_out(4, mode4, target4, int'(a4), int'(b4), int'(cin4));
   always_comb out1 = adder_out(1, mode1, target1, int'(a1), int'(b1), int'(cin1));
   assign sum4  = out4[3:0];
   assign cout4 = out4[4];
   assign sum1  = out1[0:0];
   assign cout1 = out1[1];

   adder_exhaustive_checker #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
      .a(a4), .b(b4), .cin(cin4), .dut_sum(sum4), .dut_cout(cout4),
      .busy(busy4), .done(done4), .error(err4), .err_count(cnt4),
      .fail_a(fa4), .fail_b(fb4), .fail_cin(fcin4)
   );

   adder_exhaustive_checker #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .a(a1), .b(b1), .cin(cin1), .dut_sum(sum1), .dut_cout(cout1),
      .busy(busy1), .done(done1), .error(err1), .err_count(cnt1),
      .fail_a(fa1), .fail_b(fb1), .fail_cin(fcin1)
   );

   // Observation mux so one sweep task serves both instances
   logic sel1 = 1'b0;
   logic obs_busy, obs_done, obs_err, obs_cin, obs_fcin;
   int   obs_a, obs_b, obs_fa, obs_fb, obs_cnt;
   always_comb begin
      obs_busy = sel1 ? busy1 : busy4;
      obs_done = sel1 ? done1 : done4;
      obs_err  = sel1 ? err1  : err4;
      obs_cin  = sel1 ? cin1  : cin4;
      obs_fcin = sel1 ? fcin1 : fcin4;
      obs_a    = sel1 ? int'(a1)   : int'(a4);
      obs_b    = sel1 ? int'(b1)   : int'(b4);
      obs_fa   = sel1 ? int'(fa1)  : int'(fa4);
      obs_fb   = sel1 ? int'(fb1)  : int'(fb4);
      obs_cnt  = sel1 ? int'(cnt1) : int'(cnt4);
   end

   // Reference: walk every vector in order, score it, note first failure and where the sweep ends
   task automatic model(input int w, input int mode, input int target,
                        output int cnt, output int first, output int last);
      int n, mask, av, bv, cv;
      n = 1 << (2*w + 1);
      mask = (1 << w) - 1;
      cnt = 0; first = -1; last = n - 1;
      for (int i = 0; i < n; i++) begin
         bv = i & mask;
         av = (i >> w) & mask;
         cv = i >> (2*w);
         if (adder_out(w, mode, target, av, bv, cv) != av + bv + cv) begin
            cnt++;
            if (first < 0) first = i;
            if (STOP) begin
               last = i;
               break;
            end
         end
      end
   endtask

   task automatic set_start(input bit v);
      if (sel1) start1 = v; else start4 = v;
   endtask

   task automatic set_abort(input bit v);
      if (sel1) abort1 = v; else abort4 = v;
   endtask

   // Full sweep from a start pulse; optional random start pulses while running
   task automatic do_sweep(input string name, input bit use1, input int mode, input int target,
                           input bit pulses);
      int w, mask, cnt, first, last, cycles, limit, exp_fa, exp_fb, exp_fc;
      bit overlap;
      sel1 = use1;
      w = use1 ? 1 : 4;
      mask = (1 << w) - 1;
      if (use1) begin mode1 = mode; target1 = target; end
      else begin mode4 = mode; target4 = target; end
      model(w, mode, target, cnt, first, last);
      exp_fa = (first < 0) ? 0 : (first >> w) & mask;
      exp_fb = (first < 0) ? 0 : first & mask;
      exp_fc = (first < 0) ? 0 : first >> (2*w);
      limit = last + 1 + 20;
      overlap = 1'b0;

      set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      tests_run++;
      if (obs_busy !== 1'b1 || obs_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s busy_after_start: busy=%0b done=%0b, want busy=1 done=0", name, obs_busy, obs_done);
      end
      cycles = 0;
      while (!obs_done && cycles < limit) begin
         @(posedge clk); #1;
         cycles++;
         if (obs_busy && obs_done) overlap = 1'b1;
         if (!obs_done) set_start(pulses && ($urandom_range(0, 15) == 0));
      end
      set_start(1'b0);

      tests_run++;
      if (cycles !== last + 1) begin
         tests_failed++;
         $display("FAIL %s done_edge: got %0d, want %0d", name, cycles, last + 1);
      end
      tests_run++;
      if (overlap !== 1'b0 || obs_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s busy_done_overlap: overlap=%0b busy=%0b, want 0 0", name, overlap, obs_busy);
      end
      tests_run++;
      if (obs_cnt !== cnt || obs_err !== (cnt > 0)) begin
         tests_failed++;
         $display("FAIL %s err_count: got %0d err=%0b, want %0d err=%0b", name, obs_cnt, obs_err, cnt, cnt > 0);
      end
      tests_run++;
      if (obs_fa !== exp_fa || obs_fb !== exp_fb || obs_fcin !== exp_fc[0]) begin
         tests_failed++;
         $display("FAIL %s fail_vector: got a=%0d b=%0d cin=%0b, want a=%0d b=%0d cin=%0d",
                  name, obs_fa, obs_fb, obs_fcin, exp_fa, exp_fb, exp_fc);
      end
      tests_run++;
      if (obs_a !== ((last >> w) & mask) || obs_b !== (last & mask) || obs_cin !== (last >> (2*w))) begin
         tests_failed++;
         $display("FAIL %s final_vector: got a=%0d b=%0d cin=%0b, want index %0d", name, obs_a, obs_b, obs_cin, last);
      end
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (obs_done !== 1'b1 || obs_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s done_hold: done=%0b busy=%0b, want 1 0", name, obs_done, obs_busy);
      end
      $display("[TB] sweep %s: W=%0d mode=%0d edges=%0d err_count=%0d first=%0d", name, w, mode, cycles, obs_cnt, first);
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({a4, b4, cin4, busy4, done4, err4, cnt4, fa4, fb4, fcin4} !== '0 ||
          {a1, b1, cin1, busy1, done1, err1, cnt1, fa1, fb1, fcin1} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: some output nonzero (busy4=%0b cnt4=%0d a4=%0d), want all 0", busy4, cnt4, a4);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("[TB] reset released");
   endtask

   task automatic test_basic_faults;
      do_sweep("good4", 1'b0, 0, 0, 1'b0);
      do_sweep("sum0_stuck4", 1'b0, 1, 0, 1'b0);
      do_sweep("cout_stuck4", 1'b0, 2, 0, 1'b0);
   endtask

   task automatic test_random_fault;
      for (int k = 0; k < 3; k++) begin
         do_sweep("one_bad_vec4", 1'b0, 4, int'($urandom_range(0, 511)), 1'b0);
      end
   endtask

   task automatic test_start_during_run;
      do_sweep("start_pulses4", 1'b0, 0, 0, 1'b1);
   endtask

   task automatic test_abort;
      int e;
      sel1 = 1'b0;
      mode4 = 0;
      e = int'($urandom_range(20, 480));
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      repeat (e - 1) @(posedge clk);
      #1;
      abort4 = 1'b1;
      @(posedge clk); #1;
      abort4 = 1'b0;
      tests_run++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || cnt4 !== '0 || err4 !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_state: busy=%0b done=%0b cnt=%0d err=%0b, want 0 0 0 0", busy4, done4, cnt4, err4);
      end
      tests_run++;
      if (int'({cin4, a4, b4}) !== e - 1) begin
         tests_failed++;
         $display("FAIL abort_frozen_vector: got %0d, want %0d", {cin4, a4, b4}, e - 1);
      end
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (busy4 !== 1'b0 || done4 !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_stays_idle: busy=%0b done=%0b, want 0 0", busy4, done4);
      end
      $display("[TB] abort at edge %0d: vector=%0d", e, {cin4, a4, b4});
   endtask

   task automatic test_abort_vs_start;
      int cnt, first, last;
      do_sweep("sum0_before_abort4", 1'b0, 1, 0, 1'b0);
      model(4, 1, 0, cnt, first, last);
      start4 = 1'b1;
      abort4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      abort4 = 1'b0;
      tests_run++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || int'(cnt4) !== cnt || err4 !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_beats_start: busy=%0b done=%0b cnt=%0d err=%0b, want 0 0 %0d 1",
                  busy4, done4, cnt4, err4, cnt);
      end
      $display("[TB] abort+start together: busy=%0b cnt=%0d", busy4, cnt4);
   endtask

   task automatic test_reset_midsweep;
      sel1 = 1'b0;
      mode4 = 1;
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      repeat (299) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({a4, b4, cin4, busy4, done4, err4, cnt4, fa4, fb4, fcin4} !== '0) begin
         tests_failed++;
         $display("FAIL reset_midsweep: busy=%0b err=%0b cnt=%0d a=%0d b=%0d, want all 0", busy4, err4, cnt4, a4, b4);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (busy4 !== 1'b0 || done4 !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: busy=%0b done=%0b, want 0 0", busy4, done4);
      end
      $display("[TB] reset at edge 300 cleared outputs");
      do_sweep("sum0_after_reset4", 1'b0, 1, 0, 1'b0);
   endtask

   task automatic test_width1;
      do_sweep("good1", 1'b1, 0, 0, 1'b0);
      do_sweep("cout_inv1", 1'b1, 3, 0, 1'b0);
      do_sweep("one_bad_vec1", 1'b1, 4, int'($urandom_range(0, 7)), 1'b1);
   endtask

   task automatic test_back_to_back;
      do_sweep("b2b_a4", 1'b0, 2, 0, 1'b0);
      do_sweep("b2b_b4", 1'b0, 0, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic_faults();
      test_random_fault();
      test_start_during_run();
      test_abort();
      test_abort_vs_start();
      test_reset_midsweep();
      test_width1();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/adder_exhaustive_checker.md
# adder_exhaustive_checker

Synthesizable, parametrised exhaustive checker for an N-bit adder with carry-in. On a start pulse it drives every {cin, a, b} combination into an external adder under test, one vector per clock, and compares {dut_cout, dut_sum} against a+b+cin. It reports pass/fail, a mismatch count and the first failing vector. It sits beside the adder datapath as an on-chip self-test, replacing the testbench-only stimulus loop with clocked hardware.

## Interface
- WIDTH, 4: operand width of the adder under test; legal range 1..16.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE
- abort  input  1  synchronous; returns to IDLE from any state
- a  output  WIDTH  operand A to the DUT (registered)
- b  output  WIDTH  operand B to the DUT (registered)
- cin  output  1  carry-in to the DUT (registered)
- dut_sum  input  WIDTH  DUT sum; combinational from a, b, cin
- dut_cout  input  1  DUT carry-out
- busy  output  1  high in RUN
- done  output  1  high in DONE; held until start, abort or reset
- error  output  1  sticky; set on the first mismatch of a sweep
- err_count  output  2*WIDTH+2  mismatches in the current sweep; never wraps
- fail_a, fail_b  output  WIDTH  a, b of the first mismatch
- fail_cin  output  1  cin of the first mismatch

## Operation
- States: IDLE, RUN, DONE.
- IDLE --start--> RUN: clear a, b, cin, error, err_count and fail_*.
- DONE --start--> RUN: same clearing; a new sweep begins.
- RUN: at each rising edge, compare the current vector: mismatch = ({dut_cout, dut_sum} != a + b + cin).
  - The golden sum is computed at WIDTH+1 bits.
  - On a mismatch, increment err_count and set error.
  - If error was 0 before this edge, latch a, b and cin into fail_*.
- Vector order: b increments fastest. When b wraps from all-ones, it returns to 0 and a increments. When a also wraps, cin toggles from 0 to 1. This gives 2^(2*WIDTH+1) vectors in total.
- After the last vector ({cin, a, b} all ones) is compared, go to DONE. a, b and cin hold the last vector.
- abort: from any state, go to IDLE next edge.
  - Clears busy and done.
  - Leaves error, err_count and fail_* frozen.
  - abort wins over start when both are high in the same cycle.
- start while in RUN is ignored.
- Reset (asynchronous, any time, including mid-sweep):
  - State returns to IDLE.
  - All outputs are 0: a, b, cin, busy, done, error, err_count, fail_a, fail_b, fail_cin.

## Timing
- The DUT path from a/b/cin to dut_sum/dut_cout must settle within one clock period.
- Start sampled at edge 0: busy=1 and vector 0 is driven after edge 0.
- Vector k is driven after edge k and compared at edge k+1.
- For a full sweep, done=1 and busy=0 after edge 2^(2*WIDTH+1). For WIDTH=4 that is edge 512.
- err_count, error and fail_* update at the same edge that compares the vector.
- done and busy are never high together.

## Configuration
- STOP_ON_FAIL_EN defined:
  - RUN goes to DONE at the edge that detects the first mismatch.
  - err_count ends at 1.
  - a, b and cin hold the failing vector.
- STOP_ON_FAIL_EN undefined: the sweep always runs all vectors; err_count is the total mismatch count.

## Test plan
- Correct WIDTH=4 ripple-carry adder, start at edge 0 -> busy through edge 511; done=1 after edge 512; error=0; err_count=0.
- DUT with sum[0] stuck at 0, macro undefined -> after edge 512: done=1, error=1, err_count=256, fail_a=0, fail_b=1, fail_cin=0.
- DUT with cout stuck at 0, macro undefined -> err_count=256, fail_a=1, fail_b=15, fail_cin=0. Same DUT with STOP_ON_FAIL_EN -> done after edge 32, err_count=1, a=1, b=15, cin=0.
- Correct adder: start pulses during RUN -> ignored; done still after edge 512. abort at edge 100 -> IDLE at edge 100; busy=0, done=0; err_count=0 frozen.
- rst_n low mid-sweep (edge 300) with the sum[0]-stuck DUT -> all outputs 0 immediately and state IDLE. A new start then gives the full 512-cycle sweep with err_count=256.
- WIDTH=1 correct adder -> done after edge 8, err_count=0. WIDTH=1 DUT that inverts cout -> err_count=8.
